// File: rtl/pattern_sweep_capture_if.sv
// rtl/pattern_sweep_capture_if.sv - record stream carrying {pattern, response} from the sweep engine to the logger
interface pattern_sweep_capture_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
);
  logic             rec_valid;
  logic             rec_ready;
  logic [N_IN-1:0]  rec_pattern;
  logic [N_OUT-1:0] rec_resp;

  modport master (output rec_valid, rec_pattern, rec_resp, input rec_ready);
  modport slave  (input rec_valid, rec_pattern, rec_resp, output rec_ready);
endinterface

// File: rtl/pattern_sweep_capture.sv
// rtl/pattern_sweep_capture.sv - exhaustive input sweep with settle/sample and record stream out
// Optional response signature (sig port) when PSC_MISR_EN is defined.
module pattern_sweep_capture #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  pattern_sweep_capture_if.master rec
`ifdef PSC_MISR_EN
  ,
  output logic [15:0]       sig
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD, S_DONE} state_t;

  localparam logic [N_IN-1:0] LAST_PAT = '1;
  localparam logic [7:0]      CNT_LAST = 8'(SETTLE - 1);

  state_t           state_q;
  logic [N_IN-1:0]  pattern_q;
  logic [7:0]       count_q;
  logic [N_IN-1:0]  dut_in_q;
  logic             valid_q;
  logic [N_IN-1:0]  rec_pattern_q;
  logic [N_OUT-1:0] rec_resp_q;
  logic             done_q;

`ifdef PSC_MISR_EN
  logic [15:0] sig_q;
  logic [15:0] resp_ext;
  assign resp_ext = 16'(rec_resp_q);
  assign sig      = sig_q;
`endif

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pattern_q     <= '0;
      count_q       <= '0;
      dut_in_q      <= '0;
      valid_q       <= 1'b0;
      rec_pattern_q <= '0;
      rec_resp_q    <= '0;
      done_q        <= 1'b0;
`ifdef PSC_MISR_EN
      sig_q         <= '0;
`endif
    end else if (abort) begin
      // abort overrides any handshake or start seen on the same edge
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      dut_in_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q   <= 1'b0;
          dut_in_q <= '0;
          if (start) begin
            pattern_q <= '0;
            count_q   <= '0;
            state_q   <= S_SETTLE;
`ifdef PSC_MISR_EN
            sig_q     <= '0;
`endif
          end
        end
        S_SETTLE: begin
          dut_in_q <= pattern_q;
          count_q  <= count_q + 8'd1;
          if (count_q == CNT_LAST) begin
            rec_pattern_q <= pattern_q;
            rec_resp_q    <= dut_out;
            valid_q       <= 1'b1;
            state_q       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (valid_q && rec.rec_ready) begin
            valid_q <= 1'b0;
`ifdef PSC_MISR_EN
            sig_q <= ({sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)) ^ resp_ext;
`endif
            // the all-ones pattern ends the sweep; the counter never wraps
            if (pattern_q == LAST_PAT) begin
              dut_in_q <= '0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              pattern_q <= pattern_q + 1'b1;
              dut_in_q  <= pattern_q + 1'b1;
              count_q   <= '0;
              state_q   <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          done_q   <= 1'b0;
          dut_in_q <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = (state_q == S_SETTLE) || (state_q == S_HOLD);
  assign done            = done_q;
  assign dut_in          = dut_in_q;
  assign rec.rec_valid   = valid_q;
  assign rec.rec_pattern = rec_pattern_q;
  assign rec.rec_resp    = rec_resp_q;

endmodule

// File: tb/tb_pattern_sweep_capture.sv
// tb/tb_pattern_sweep_capture.sv - directed bench for pattern_sweep_capture (SETTLE=1 and SETTLE=3 instances)
module tb_pattern_sweep_capture;

  logic CK;
  logic rst_n;
  logic start, abort, ready;
  logic sel;
  int   mode;
  int   checks = 0;
  int   failures = 0;

  logic       start0, start1;
  logic       busy0, busy1, done0, done1;
  logic [2:0] din0, din1;
  logic       dout0, dout1;

  pattern_sweep_capture_if #(.N_IN(3), .N_OUT(1)) rif0();
  pattern_sweep_capture_if #(.N_IN(3), .N_OUT(1)) rif1();

`ifdef PSC_MISR_EN
  logic [15:0] sig0, sig1, sig_s, last_sig;
  assign sig_s = sel ? sig1 : sig0;
`endif

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign rif0.rec_ready = ready;
  assign rif1.rec_ready = ready;

  pattern_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u0 (
    .CK(CK), .reset(rst_n), .start(start0), .abort(abort),
    .busy(busy0), .done(done0), .dut_in(din0), .dut_out(dout0),
    .rec(rif0)
`ifdef PSC_MISR_EN
    , .sig(sig0)
`endif
  );

  pattern_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE(3)) u1 (
    .CK(CK), .reset(rst_n), .start(start1), .abort(abort),
    .busy(busy1), .done(done1), .dut_in(din1), .dut_out(dout1),
    .rec(rif1)
`ifdef PSC_MISR_EN
    , .sig(sig1)
`endif
  );

  function automatic logic resp_of(input int m, input logic [2:0] p);
    case (m)
      0:       return ^p;
      1:       return (p == 3'd0);
      default: return 1'b0;
    endcase
  endfunction

  always_comb dout0 = resp_of(mode, din0);
  always_comb dout1 = resp_of(mode, din1);

  logic       v_s, busy_s, done_s, resp_s;
  logic [2:0] pat_s, din_s;
  assign v_s    = sel ? rif1.rec_valid   : rif0.rec_valid;
  assign pat_s  = sel ? rif1.rec_pattern : rif0.rec_pattern;
  assign resp_s = sel ? rif1.rec_resp    : rif0.rec_resp;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign din_s  = sel ? din1  : din0;

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one full sweep on the selected instance, checking every record and the done timing.
  task automatic run_sweep(input int settle, input int stall_pat, input int stall_len, input bit mid_start);
    int n = 0;
    int stall = 0;
    int dones = 0;
    int exp_done;
    bit fin = 0;
    bit seen = 0;
    exp_done = 8 * (settle + 1) + stall_len;
    ready = 1'b1;
    @(negedge CK);
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    chk("start_busy", busy_s, 1'b1);
    chk("start_din", din_s, 3'd0);
    for (int off = 0; off < 600 && !fin; off++) begin
      if (mid_start) start = (off == 3);
      if (done_s) begin
        dones++;
        chk("done_cycle", off, exp_done);
        chk("done_busy", busy_s, 1'b0);
`ifdef PSC_MISR_EN
        last_sig = sig_s;
`endif
        fin = 1;
      end else if (v_s) begin
        if (!seen) begin
          chk("rec_pattern", pat_s, n[2:0]);
          chk("rec_resp", resp_s, resp_of(mode, n[2:0]));
          seen = 1;
        end
        chk("hold_din", din_s, n[2:0]);
        if (n == stall_pat && stall < stall_len) begin
          chk("stall_pattern", pat_s, n[2:0]);
          ready = 1'b0;
          stall++;
        end else begin
          ready = 1'b1;
          n++;
          seen = 0;
        end
      end else if (busy_s) begin
        chk("settle_din", din_s, n[2:0]);
      end else begin
        chk("busy_drop", busy_s, 1'b1);
        fin = 1;
      end
      @(posedge CK); #1;
    end
    start = 1'b0;
    ready = 1'b1;
    if (!fin) chk("sweep_timeout", 0, 1);
    chk("records", n, 8);
    chk("done_count", dones, 1);
    chk("done_pulse", done_s, 1'b0);
    chk("idle_din", din_s, 3'd0);
    chk("idle_busy", busy_s, 1'b0);
  endtask

  initial begin
    int dones;
    bit hit;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1; sel = 1'b0; mode = 0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_valid", rif0.rec_valid, 1'b0);
    chk("rst_pattern", rif0.rec_pattern, 3'd0);
    chk("rst_resp", rif0.rec_resp, 1'b0);
    chk("rst_din", din0, 3'd0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    @(negedge CK);
    rst_n = 1'b1;

    // parity sweep, no backpressure
    sel = 1'b0;
    run_sweep(1, -1, 0, 1'b0);

    // SETTLE=3 with 5-cycle stall on pattern 010
    sel = 1'b1;
    run_sweep(3, 2, 5, 1'b0);

    // start pulsed while busy is ignored
    sel = 1'b0;
    run_sweep(1, -1, 0, 1'b1);

    // abort during SETTLE of pattern 101
    sel = 1'b1;
    ready = 1'b1;
    hit = 0;
    @(negedge CK);
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (busy_s && !v_s && din_s == 3'd5) begin
        abort = 1'b1;
        hit = 1;
      end else begin
        @(posedge CK); #1;
      end
    end
    chk("abort_reached", hit, 1'b1);
    @(posedge CK); #1;
    abort = 1'b0;
    chk("abort_busy", busy_s, 1'b0);
    chk("abort_valid", v_s, 1'b0);
    chk("abort_din", din_s, 3'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_s) dones++;
      @(posedge CK); #1;
    end
    chk("abort_nodone", dones, 0);
    run_sweep(3, -1, 0, 1'b0);

    // asynchronous reset while holding the record for pattern 111
    sel = 1'b0;
    ready = 1'b1;
    hit = 0;
    @(negedge CK);
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (v_s && pat_s == 3'd7) begin
        ready = 1'b0;
        hit = 1;
      end else begin
        @(posedge CK); #1;
      end
    end
    chk("prerst_reached", hit, 1'b1);
    chk("prerst_resp", resp_s, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", v_s, 1'b0);
    chk("arst_pattern", pat_s, 3'd0);
    chk("arst_resp", resp_s, 1'b0);
    chk("arst_din", din_s, 3'd0);
    chk("arst_busy", busy_s, 1'b0);
    chk("arst_done", done_s, 1'b0);
    start = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    chk("rst_start_ignored", busy_s, 1'b0);
    @(negedge CK);
    start = 1'b0;
    rst_n = 1'b1;
    ready = 1'b1;
    @(posedge CK); #1;
    chk("post_rst_idle", busy_s, 1'b0);
    run_sweep(1, -1, 0, 1'b0);

`ifdef PSC_MISR_EN
    mode = 1;
    run_sweep(1, -1, 0, 1'b0);
    chk("sig_one_hot", last_sig, 16'h0080);
    chk("sig_hold", sig_s, 16'h0080);
    mode = 2;
    run_sweep(1, -1, 0, 1'b0);
    chk("sig_zero", last_sig, 16'h0000);
    mode = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
